gf_mul_scheduler: RTL

Shares one combinational N-bit carry-less (GF(2)) Karatsuba multiplier between four requesters and turns its raw 2N-bit product into a GF(2^N) field element. Arbitration is round-robin. Reduction is bit-serial, using a per-request reduction polynomial. Requesters use valid/ready; the consumer receives the raw product, the reduced remainder and the requester ID. It sits between crypto/ECC front-ends and the shared multiplier datapath, which it instantiates.

---
 rtl/gf_mul_scheduler_if.sv | 17 +
 rtl/gf_mul_scheduler.sv | 123 ++++++++++++
 2 files changed

// File: rtl/gf_mul_scheduler_if.sv
// gf_mul_scheduler_if: requester and consumer handshake bundle for the shared GF(2) multiplier.
interface gf_mul_scheduler_if #(parameter int N = 8);
    logic [3:0]     req_valid;
    logic [4*N-1:0] req_a;
    logic [4*N-1:0] req_b;
    logic [4*N-1:0] req_poly;
    logic [3:0]     req_ready;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic [2*N-1:0] resp_prod;
    logic [N-1:0]   resp_rem;
    modport master (output req_valid, req_a, req_b, req_poly, resp_ready,
                    input req_ready, resp_valid, resp_id, resp_prod, resp_rem);
    modport slave (input req_valid, req_a, req_b, req_poly, resp_ready,
                   output req_ready, resp_valid, resp_id, resp_prod, resp_rem);
endinterface

// File: rtl/gf_mul_scheduler.sv
// gf_mul_scheduler: round-robin share of one Karatsuba carry-less multiplier with
// bit-serial reduction of the product modulo a per-request monic polynomial.
module gf_clmul #(parameter int N = 8) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    localparam int L = N - N / 2;
    localparam logic [N-1:0] LMASK = {N{1'b1}} >> (N - L);
    function automatic logic [2*N-1:0] clm(input logic [N-1:0] x, input logic [N-1:0] y);
        logic [2*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r = y[k] ? r ^ ({{N{1'b0}}, x} << k) : r;
        return r;
    endfunction
    logic [N-1:0]   al, ah, bl, bh;
    logic [2*N-1:0] z0, z1, z2;
    // One Karatsuba level: three half-width products instead of four
    always_comb begin
        al = a & LMASK;
        ah = a >> L;
        bl = b & LMASK;
        bh = b >> L;
        z0 = clm(al, bl);
        z2 = clm(ah, bh);
        z1 = clm(al ^ ah, bl ^ bh) ^ z0 ^ z2;
        p  = (z2 << (2 * L)) ^ (z1 << L) ^ z0;
    end
endmodule

module gf_mul_scheduler #(parameter int N = 8) (
    input logic              clk,
    input logic              rst_n,
    gf_mul_scheduler_if.slave bus
);
    localparam int IW = $clog2(2 * N);
    typedef enum logic [1:0] {IDLE, MUL, RED, RESP} state_t;
    state_t         state_q, state_d;
    logic [1:0]     last_grant_q, last_grant_d, id_q, id_d, gid, idx;
    logic [N-1:0]   a_q, a_d, b_q, b_d, poly_q, poly_d;
    logic [2*N-1:0] prod_q, prod_d, acc_q, acc_d, mul_p, pmask;
    logic [IW-1:0]  i_q, i_d;
    logic [3:0]     ready_c;
    logic           found;

    gf_clmul #(.N(N)) u_mul (.a(a_q), .b(b_q), .p(mul_p));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        poly_d       = poly_q;
        prod_d       = prod_q;
        acc_d        = acc_q;
        i_d          = i_q;
        ready_c      = '0;
        found        = 1'b0;
        gid          = last_grant_q;
        idx          = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            idx   = last_grant_q + 2'(k);
            gid   = (!found && bus.req_valid[idx]) ? idx : gid;
            found = found | bus.req_valid[idx];
        end
        pmask = {{(N-1){1'b0}}, 1'b1, poly_q} << (i_q - IW'(N));
        case (state_q)
            IDLE: if (found) begin
                ready_c[gid] = 1'b1;
                a_d          = bus.req_a[int'(gid)*N +: N];
                b_d          = bus.req_b[int'(gid)*N +: N];
                poly_d       = bus.req_poly[int'(gid)*N +: N];
                id_d         = gid;
                last_grant_d = gid;
                state_d      = MUL;
            end
            MUL: begin
                prod_d  = mul_p;
                acc_d   = mul_p;
                i_d     = IW'(2 * N - 1);
                state_d = RED;
            end
            RED: begin
                acc_d   = acc_q[i_q] ? acc_q ^ pmask : acc_q;
                i_d     = i_q - IW'(1);
                state_d = (i_q == IW'(N)) ? RESP : RED;
            end
            default: state_d = bus.resp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 2'd3;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            poly_q       <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            i_q          <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            poly_q       <= poly_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            i_q          <= i_d;
        end
    end

    // Accept pulse is masked by reset so nothing is granted while rst_n is low
    assign bus.req_ready  = rst_n ? ready_c : 4'b0;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_id    = bus.resp_valid ? id_q : 2'b0;
    assign bus.resp_prod  = bus.resp_valid ? prod_q : '0;
    assign bus.resp_rem   = bus.resp_valid ? acc_q[N-1:0] : '0;
endmodule
